// File: rtl/instr_register_loader.sv
// instr_register_loader
//   Buffers instruction requests in a small FIFO and issues at most one
//   write per cycle to the instr_register load port. The write address comes
//   either from an internal auto-incrementing pointer or from the request.
//   The loader also tracks which register locations have been written and
//   discards entries that carry an illegal opcode.
//
// Ports
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid/in_ready   : request handshake (push when both high)
//   in_opcode           : 4-bit opcode, 0..7 legal
//   in_operand_a/b      : 32-bit signed operands
//   in_addr             : explicit write address
//   in_addr_mode        : 0 = auto pointer, 1 = in_addr
//   hold                : stall issue (accept side unaffected)
//   clear               : synchronous soft clear, same effect as reset
//   load_en             : write strobe to instr_register
//   write_pointer       : registered write address
//   opcode, operand_a/b : registered data to the register
//   written_mask        : bit i set once location i has been written
//   wrapped             : sticky, auto pointer wrapped 31 -> 0
//   drop_count          : saturating count of discarded illegal entries
//   fifo_count          : current FIFO occupancy
module instr_register_loader #(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [31:0]              in_operand_a,
  input  logic [31:0]              in_operand_b,
  input  logic [4:0]               in_addr,
  input  logic                     in_addr_mode,
  input  logic                     hold,
  input  logic                     clear,
  output logic                     load_en,
  output logic [4:0]               write_pointer,
  output logic [3:0]               opcode,
  output logic [31:0]              operand_a,
  output logic [31:0]              operand_b,
  output logic [NUM_REGS-1:0]      written_mask,
  output logic                     wrapped,
  output logic [7:0]               drop_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + 5 + 4 + 32 + 32;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_reg, state_next;
  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]      count_reg;
  logic [4:0]       auto_ptr_reg;

  logic             push, pop, issue, head_legal;
  logic             head_mode;
  logic [4:0]       head_addr;
  logic [3:0]       head_opcode;
  logic [31:0]      head_a, head_b;
  logic [4:0]       issue_addr;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign in_ready   = (count_reg != (AW+1)'(DEPTH));
  assign fifo_count = count_reg;

  assign push = in_valid && in_ready;
  assign pop  = (count_reg != '0) && !hold;

  assign {head_mode, head_addr, head_opcode, head_a, head_b} = fifo_mem[rd_ptr_reg];

  // Opcodes 8..15 have the top bit set; such entries are popped but dropped.
  assign head_legal = !head_opcode[3];
  assign issue      = pop && head_legal;
  assign issue_addr = head_mode ? head_addr : auto_ptr_reg;

  // FIFO storage: no reset needed, pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_addr_mode, in_addr, in_opcode, in_operand_a, in_operand_b};
    end
  end

  // Issue FSM: ISSUE lasts exactly one cycle per legal pop.
  always_comb begin
    state_next = IDLE;
    if (issue) begin
      state_next = ISSUE;
    end
  end

  assign load_en = (state_reg == ISSUE);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_reg     <= IDLE;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      auto_ptr_reg  <= '0;
      write_pointer <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      written_mask  <= '0;
      wrapped       <= 1'b0;
      drop_count    <= '0;
    end else begin
      state_reg <= state_next;

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      // Mask and wrap flag update on the same edge that raises load_en.
      if (issue) begin
        write_pointer            <= issue_addr;
        opcode                   <= head_opcode;
        operand_a                <= head_a;
        operand_b                <= head_b;
        written_mask[issue_addr] <= 1'b1;
        if (!head_mode) begin
          auto_ptr_reg <= auto_ptr_reg + 1'b1;
          if (auto_ptr_reg == 5'd31) begin
            wrapped <= 1'b1;
          end
        end
      end

      if (pop && !head_legal && drop_count != 8'hFF) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_register_loader.sv
// Testbench for instr_register_loader: directed scenarios with literal
// expectations, followed by randomized traffic. A queue-based reference
// model predicts every output each cycle and a compare process checks them.
module tb_instr_register_loader;

  localparam int DEPTH = 4;

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_PASSA = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_MOD   = 4'd7;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [31:0] in_operand_a;
  logic [31:0] in_operand_b;
  logic [4:0]  in_addr;
  logic        in_addr_mode;
  logic        hold;
  logic        clear;
  logic        load_en;
  logic [4:0]  write_pointer;
  logic [3:0]  opcode;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] written_mask;
  logic        wrapped;
  logic [7:0]  drop_count;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  instr_register_loader #(.DEPTH(DEPTH), .NUM_REGS(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_operand_a (in_operand_a),
    .in_operand_b (in_operand_b),
    .in_addr      (in_addr),
    .in_addr_mode (in_addr_mode),
    .hold         (hold),
    .clear        (clear),
    .load_en      (load_en),
    .write_pointer(write_pointer),
    .opcode       (opcode),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .written_mask (written_mask),
    .wrapped      (wrapped),
    .drop_count   (drop_count),
    .fifo_count   (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic        mode;
  } req_t;

  req_t        mq[$];
  logic        m_le;
  logic [4:0]  m_wp;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [31:0] m_mask;
  logic        m_wrapped;
  int          m_drop;
  int          m_ptr;
  bit          model_started = 0;

  always @(posedge clk) begin
    req_t e;
    bit   do_push, do_pop;
    if (!reset_n || clear) begin
      mq.delete();
      m_le = 0; m_wp = 0; m_op = 0; m_a = 0; m_b = 0;
      m_mask = 0; m_wrapped = 0; m_drop = 0; m_ptr = 0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && !hold;
      m_le = 0;
      if (do_pop) begin
        e = mq.pop_front();
        if (int'(e.op) < 8) begin
          m_le = 1;
          m_wp = e.mode ? e.addr : 5'(m_ptr);
          m_op = e.op;
          m_a  = e.a;
          m_b  = e.b;
          m_mask[m_wp] = 1'b1;
          if (!e.mode) begin
            if (m_ptr == 31) m_wrapped = 1;
            m_ptr = (m_ptr + 1) % 32;
          end
        end else if (m_drop < 255) begin
          m_drop = m_drop + 1;
        end
      end
      if (do_push) begin
        e.op = in_opcode; e.a = in_operand_a; e.b = in_operand_b;
        e.addr = in_addr; e.mode = in_addr_mode;
        mq.push_back(e);
      end
    end
    model_started = 1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_started) begin
      chk("load_en",       32'(load_en),       32'(m_le));
      chk("write_pointer", 32'(write_pointer), 32'(m_wp));
      chk("opcode",        32'(opcode),        32'(m_op));
      chk("operand_a",     operand_a,          m_a);
      chk("operand_b",     operand_b,          m_b);
      chk("written_mask",  written_mask,       m_mask);
      chk("wrapped",       32'(wrapped),       32'(m_wrapped));
      chk("drop_count",    32'(drop_count),    32'(m_drop));
      chk("fifo_count",    32'(fifo_count),    32'(mq.size()));
      chk("in_ready",      32'(in_ready),      32'(mq.size() != DEPTH));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ad, input logic md);
    in_valid = 1'b1; in_opcode = op; in_operand_a = a; in_operand_b = b;
    in_addr = ad; in_addr_mode = md;
  endtask

  // Present a request and return at the negedge after it was accepted.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] ad, input logic md);
    bit done;
    done = 0;
    drive(op, a, b, ad, md);
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; in_opcode = OP_ADD; in_operand_a = 32'd1;
    in_operand_b = 32'd2; in_addr = 5'd0; in_addr_mode = 1'b0; hold = 1'b0; clear = 1'b0;

    // Reset with in_valid asserted: nothing may be pushed.
    repeat (2) @(negedge clk);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_load_en", 32'(load_en), 32'd0);
    chk("rst_mask", written_mask, 32'd0);
    reset_n = 1'b1;
    idle();
    @(negedge clk);

    // Auto burst on consecutive cycles.
    drive(OP_ADD, 32'd5, 32'd3, 5'd0, 1'b0);
    @(negedge clk);
    chk("burst_le_before", 32'(load_en), 32'd0);
    drive(OP_SUB, 32'hFFFF_FFFC, 32'd2, 5'd0, 1'b0);
    @(negedge clk);
    chk("burst_le0", 32'(load_en), 32'd1);
    chk("burst_wp0", 32'(write_pointer), 32'd0);
    chk("burst_a0", operand_a, 32'd5);
    drive(OP_MOD, 32'd9, 32'd4, 5'd0, 1'b0);
    @(negedge clk);
    chk("burst_le1", 32'(load_en), 32'd1);
    chk("burst_wp1", 32'(write_pointer), 32'd1);
    chk("burst_a1", operand_a, 32'hFFFF_FFFC);
    idle();
    @(negedge clk);
    chk("burst_wp2", 32'(write_pointer), 32'd2);
    chk("burst_op2", 32'(opcode), 32'(OP_MOD));
    @(negedge clk);
    chk("burst_le_after", 32'(load_en), 32'd0);
    chk("burst_mask", written_mask, 32'h7);

    // Backpressure: fill under hold, fifth waits until room appears.
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(OP_ADD, 32'(i + 10), 32'(i), 5'd0, 1'b0);
    chk("bp_count_full", 32'(fifo_count), 32'd4);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    drive(OP_SUB, 32'd99, 32'd1, 5'd0, 1'b0);
    @(negedge clk);
    chk("bp_count_held", 32'(fifo_count), 32'd4);
    chk("bp_le_held", 32'(load_en), 32'd0);
    hold = 1'b0;
    send(OP_SUB, 32'd99, 32'd1, 5'd0, 1'b0);
    idle();
    repeat (6) @(negedge clk);
    chk("bp_count_drained", 32'(fifo_count), 32'd0);
    chk("bp_mask", written_mask, 32'hFF);
    chk("bp_last_a", operand_a, 32'd99);

    // Wrap: 33 auto issues, then one explicit address.
    pulse_clear();
    for (int i = 0; i < 33; i++) send(OP_PASSA, 32'(i), 32'(~i), 5'd0, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    chk("wrap_flag", 32'(wrapped), 32'd1);
    chk("wrap_mask", written_mask, 32'hFFFF_FFFF);
    chk("wrap_last_wp", 32'(write_pointer), 32'd0);
    chk("wrap_last_a", operand_a, 32'd32);
    send(OP_ADD, 32'd77, 32'd1, 5'd7, 1'b1);
    idle();
    @(negedge clk);
    chk("explicit_le", 32'(load_en), 32'd1);
    chk("explicit_wp", 32'(write_pointer), 32'd7);
    send(OP_ADD, 32'd78, 32'd1, 5'd20, 1'b0);
    idle();
    @(negedge clk);
    chk("auto_after_explicit_wp", 32'(write_pointer), 32'd1);

    // Illegal opcode followed by a legal PASSA.
    pulse_clear();
    drive(4'd12, 32'd1, 32'd1, 5'd0, 1'b0);
    @(negedge clk);
    drive(OP_PASSA, 32'd42, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    idle();
    chk("illegal_le", 32'(load_en), 32'd0);
    chk("illegal_drop", 32'(drop_count), 32'd1);
    @(negedge clk);
    chk("illegal_next_le", 32'(load_en), 32'd1);
    chk("illegal_next_wp", 32'(write_pointer), 32'd0);
    chk("illegal_mask", written_mask, 32'h1);

    // Clear with two entries buffered and a push in the same cycle.
    hold = 1'b1;
    send(OP_ADD, 32'd1, 32'd1, 5'd0, 1'b0);
    send(OP_SUB, 32'd2, 32'd2, 5'd0, 1'b0);
    drive(OP_MOD, 32'd3, 32'd3, 5'd0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle();
    hold = 1'b0;
    chk("clear_count", 32'(fifo_count), 32'd0);
    chk("clear_mask", written_mask, 32'd0);
    chk("clear_drop", 32'(drop_count), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("clear_no_le", 32'(load_en), 32'd0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      in_opcode    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      in_operand_a = $urandom;
      in_operand_b = $urandom;
      in_addr      = 5'($urandom_range(0, 31));
      in_addr_mode = 1'($urandom_range(0, 1));
      hold         = ($urandom_range(0, 4) == 0);
      clear        = ($urandom_range(0, 99) < 2);
      reset_n      = !($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    idle();
    hold = 1'b0; clear = 1'b0; reset_n = 1'b1;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
